// File: rtl/acq_vp_pkg.sv
// acq_vp_pkg: shared types and constants for the acquisition viewport RAM.
//   acq_state_t : acquisition state encoding, also driven out on state_o
//   DATA_W      : sample / viewport data width
//   ADDR_W      : default word-address width
//   VP_RD/VP_WR : direction of a latched viewport request
package acq_vp_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } acq_state_t;

  localparam logic VP_RD = 1'b0;
  localparam logic VP_WR = 1'b1;

endpackage

// File: rtl/acq_vp_spram.sv
// acq_vp_spram: single-port inferred RAM, write-first, registered read
// (1-cycle latency), contents not reset.
//   clk   : clock
//   we    : write enable
//   addr  : word address
//   wdata : write data
//   rdata : read data, registered; shows wdata on a write cycle
module acq_vp_spram #(
  parameter int ADDR_W = acq_vp_pkg::ADDR_W,
  parameter int DATA_W = acq_vp_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata     <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/acq_vp_ram.sv
// acq_vp_ram: acquisition buffer behind the acqVP memory viewport.
// A 16-bit sample stream is stored in a circular single-port RAM under an
// arm / trigger / post-trigger state machine. Viewport read/write strobes are
// latched into a single pending request and served when the RAM port is not
// taken by an acquisition write; each accepted strobe gets one Done pulse.
//
// Ports:
//   Clk, Rst            : clock, synchronous active-high reset
//   acqVP_VMEAddr_i     : viewport word address (sampled on strobe)
//   acqVP_VMEWrData_i   : viewport write data (sampled on strobe)
//   acqVP_VMERdMem_i    : viewport read strobe
//   acqVP_VMEWrMem_i    : viewport write strobe
//   acqVP_VMERdData_o   : read data, valid while RdDone is high (0 otherwise)
//   acqVP_VMERdDone_o   : read acknowledge pulse
//   acqVP_VMEWrDone_o   : write acknowledge pulse
//   sample_i            : acquisition sample
//   sample_valid_i      : sample qualifier
//   arm_i, trig_i       : arm / trigger pulses
//   post_trig_i         : post-trigger sample count, latched on arm (0 -> 1)
//   state_o             : 0=IDLE 1=ARMED 2=POST 3=DONE
//   trig_addr_o         : RAM address of the trigger sample
//   wr_ptr_o            : next acquisition write address
//   wrapped_o           : (ACQ_VP_RAM_WRAP_FLAG_EN only) write pointer wrapped
//                         since the last arm
//
// Optional feature macro: ACQ_VP_RAM_WRAP_FLAG_EN
module acq_vp_ram
  import acq_vp_pkg::*;
#(
  parameter int ADDR_W        = acq_vp_pkg::ADDR_W,
  parameter int POST_TRIG_DEF = 1024
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [ADDR_W-1:0] acqVP_VMEAddr_i,
  input  logic [15:0]       acqVP_VMEWrData_i,
  input  logic              acqVP_VMERdMem_i,
  input  logic              acqVP_VMEWrMem_i,
  output logic [15:0]       acqVP_VMERdData_o,
  output logic              acqVP_VMERdDone_o,
  output logic              acqVP_VMEWrDone_o,
  input  logic [15:0]       sample_i,
  input  logic              sample_valid_i,
  input  logic              arm_i,
  input  logic              trig_i,
  input  logic [ADDR_W-1:0] post_trig_i,
  output logic [1:0]        state_o,
  output logic [ADDR_W-1:0] trig_addr_o,
  output logic [ADDR_W-1:0] wr_ptr_o
`ifdef ACQ_VP_RAM_WRAP_FLAG_EN
  ,
  output logic              wrapped_o
`endif
);

  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  acq_state_t        state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] trig_addr;
  logic [ADDR_W-1:0] post_cnt;
  logic              trig_seen;

  logic              vp_pend;
  logic              vp_dir;
  logic [ADDR_W-1:0] vp_addr;
  logic [DATA_W-1:0] vp_wdata;
  logic              rd_done;
  logic              wr_done;

  logic              acq_active;
  logic              acq_wr;
  logic              vp_serve;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  assign acq_active = (state == ST_ARMED) || (state == ST_POST);
  assign acq_wr     = acq_active && sample_valid_i;
  assign vp_serve   = vp_pend && !acq_wr;

  // Acquisition owns the port; a viewport write is only committed outside
  // ARMED/POST so acquired data cannot be overwritten.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = vp_addr;
    ram_wdata = vp_wdata;
    if (acq_wr) begin
      ram_we    = 1'b1;
      ram_addr  = wr_ptr;
      ram_wdata = sample_i;
    end else if (vp_serve && (vp_dir == VP_WR) && !acq_active) begin
      ram_we = 1'b1;
    end
    if (Rst) ram_we = 1'b0;
  end

  acq_vp_spram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_spram (
    .clk   (Clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Viewport request: strobes are ignored while one is pending; a combined
  // read+write strobe is taken as a read.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      vp_pend  <= 1'b0;
      vp_dir   <= VP_RD;
      vp_addr  <= '0;
      vp_wdata <= '0;
      rd_done  <= 1'b0;
      wr_done  <= 1'b0;
    end else begin
      rd_done <= vp_serve && (vp_dir == VP_RD);
      wr_done <= vp_serve && (vp_dir == VP_WR);
      if (vp_serve) begin
        vp_pend <= 1'b0;
      end else if (!vp_pend && (acqVP_VMERdMem_i || acqVP_VMEWrMem_i)) begin
        vp_pend  <= 1'b1;
        vp_dir   <= acqVP_VMERdMem_i ? VP_RD : VP_WR;
        vp_addr  <= acqVP_VMEAddr_i;
        vp_wdata <= acqVP_VMEWrData_i;
      end
    end
  end

  // Acquisition state machine. The trigger sample is the valid sample that
  // coincides with trig_i or, failing that, the first one seen in POST; it
  // is also the first sample counted against post_cnt.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      trig_addr <= '0;
      post_cnt  <= ADDR_W'(POST_TRIG_DEF);
      trig_seen <= 1'b0;
    end else if (arm_i) begin
      state     <= ST_ARMED;
      wr_ptr    <= '0;
      post_cnt  <= (post_trig_i == '0) ? PTR_ONE : post_trig_i;
      trig_seen <= 1'b0;
    end else begin
      if (acq_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if ((state == ST_ARMED) && trig_i) state <= ST_POST;
      if (sample_valid_i && !trig_seen &&
          (((state == ST_ARMED) && trig_i) || (state == ST_POST))) begin
        trig_addr <= wr_ptr;
        trig_seen <= 1'b1;
      end
      if (sample_valid_i &&
          (((state == ST_ARMED) && trig_i) || (state == ST_POST))) begin
        post_cnt <= post_cnt - PTR_ONE;
        if (post_cnt == PTR_ONE) state <= ST_DONE;
      end
    end
  end

`ifdef ACQ_VP_RAM_WRAP_FLAG_EN
  logic wrapped_q;

  always_ff @(posedge Clk) begin
    if (Rst || arm_i) begin
      wrapped_q <= 1'b0;
    end else if (acq_wr && (wr_ptr == '1)) begin
      wrapped_q <= 1'b1;
    end
  end

  assign wrapped_o = wrapped_q;
`endif

  assign acqVP_VMERdData_o = rd_done ? ram_rdata : '0;
  assign acqVP_VMERdDone_o = rd_done;
  assign acqVP_VMEWrDone_o = wr_done;
  assign state_o           = state;
  assign trig_addr_o       = trig_addr;
  assign wr_ptr_o          = wr_ptr;

endmodule

// File: tb/tb_acq_vp_ram.sv
// tb_acq_vp_ram: self-checking bench for acq_vp_ram. A 16-bit-address
// instance carries the viewport and acquisition sequences; a 4-bit-address
// instance sharing the acquisition inputs covers pointer wrap.
module tb_acq_vp_ram;

  localparam int AW  = 16;
  localparam int SAW = 4;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic          Rst;
  logic [AW-1:0] vp_addr;
  logic [15:0]   vp_wdata;
  logic          vp_rd, vp_wr;
  logic [15:0]   vp_rdata;
  logic          vp_rddone, vp_wrdone;
  logic [15:0]   sample;
  logic          sv, arm, trig;
  logic [AW-1:0] post_trig;
  logic [1:0]    state;
  logic [AW-1:0] trig_addr, wr_ptr;

  logic [SAW-1:0] s_vp_addr, s_post_trig, s_trig_addr, s_wr_ptr;
  logic [15:0]    s_vp_wdata, s_vp_rdata;
  logic           s_vp_rd, s_vp_wr, s_rddone, s_wrdone;
  logic [1:0]     s_state;
`ifdef ACQ_VP_RAM_WRAP_FLAG_EN
  logic wrapped, s_wrapped;
`endif

  acq_vp_ram #(.ADDR_W(AW), .POST_TRIG_DEF(1024)) u_dut (
    .Clk               (Clk),
    .Rst               (Rst),
    .acqVP_VMEAddr_i   (vp_addr),
    .acqVP_VMEWrData_i (vp_wdata),
    .acqVP_VMERdMem_i  (vp_rd),
    .acqVP_VMEWrMem_i  (vp_wr),
    .acqVP_VMERdData_o (vp_rdata),
    .acqVP_VMERdDone_o (vp_rddone),
    .acqVP_VMEWrDone_o (vp_wrdone),
    .sample_i          (sample),
    .sample_valid_i    (sv),
    .arm_i             (arm),
    .trig_i            (trig),
    .post_trig_i       (post_trig),
    .state_o           (state),
    .trig_addr_o       (trig_addr),
    .wr_ptr_o          (wr_ptr)
`ifdef ACQ_VP_RAM_WRAP_FLAG_EN
    ,
    .wrapped_o         (wrapped)
`endif
  );

  acq_vp_ram #(.ADDR_W(SAW), .POST_TRIG_DEF(8)) u_small (
    .Clk               (Clk),
    .Rst               (Rst),
    .acqVP_VMEAddr_i   (s_vp_addr),
    .acqVP_VMEWrData_i (s_vp_wdata),
    .acqVP_VMERdMem_i  (s_vp_rd),
    .acqVP_VMEWrMem_i  (s_vp_wr),
    .acqVP_VMERdData_o (s_vp_rdata),
    .acqVP_VMERdDone_o (s_rddone),
    .acqVP_VMEWrDone_o (s_wrdone),
    .sample_i          (sample),
    .sample_valid_i    (sv),
    .arm_i             (arm),
    .trig_i            (trig),
    .post_trig_i       (s_post_trig),
    .state_o           (s_state),
    .trig_addr_o       (s_trig_addr),
    .wr_ptr_o          (s_wr_ptr)
`ifdef ACQ_VP_RAM_WRAP_FLAG_EN
    ,
    .wrapped_o         (s_wrapped)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [15:0]   data;
    logic          exp_rd;    // 1: expect RdDone, 0: expect WrDone
    logic [15:0]   exp_data;
    int            exp_lat;   // cycles from strobe cycle to Done cycle
  } vp_vec_t;

  vp_vec_t vecs [0:20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic put_sample(input logic [15:0] val, input logic trg);
    sv = 1'b1; sample = val; trig = trg;
    tick();
    sv = 1'b0; trig = 1'b0;
    tick();
  endtask

  // Strobe in cycle T; optionally a sample in T+1 (collide) and/or a second
  // write strobe in T+1 (extra). Watches T+2..T+6 for Done pulses.
  task automatic vp_txn(input logic rd, input logic wr, input logic [AW-1:0] addr,
                        input logic [15:0] data, input logic collide,
                        input logic [15:0] csample, input logic extra,
                        output int lat, output logic got_rd,
                        output logic [15:0] rdata, output int ndone);
    vp_rd = rd; vp_wr = wr; vp_addr = addr; vp_wdata = data;
    tick();
    vp_rd = 1'b0; vp_wr = extra; vp_wdata = ~data;
    if (collide) begin
      sv = 1'b1; sample = csample;
    end
    lat = 0; got_rd = 1'b0; rdata = '0; ndone = 0;
    for (int i = 2; i <= 6; i++) begin
      tick();
      vp_wr = 1'b0; sv = 1'b0;
      if (vp_rddone || vp_wrdone) begin
        ndone++;
        if (lat == 0) begin
          lat = i; got_rd = vp_rddone; rdata = vp_rdata;
        end
      end
    end
  endtask

  task automatic run_vec(input string tag, input vp_vec_t v);
    int lat, nd;
    logic grd;
    logic [15:0] rdt;
    vp_txn(v.rd, v.wr, v.addr, v.data, 1'b0, 16'h0, 1'b0, lat, grd, rdt, nd);
    check({tag, " latency"}, lat, v.exp_lat);
    check({tag, " done kind"}, grd, v.exp_rd);
    check({tag, " done count"}, nd, 1);
    if (v.exp_rd) check({tag, " rdata"}, rdt, v.exp_data);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nd, cnt;
    logic grd;
    logic [15:0] rdt;
    vp_vec_t v;

    // idle-state viewport traffic
    vecs[0]  = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000, 2};
    vecs[1]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'hBEEF, 2};
    vecs[2]  = '{1'b0, 1'b1, 16'hFFFF, 16'h1234, 1'b0, 16'h0000, 2};
    vecs[3]  = '{1'b0, 1'b1, 16'h0000, 16'hA5A5, 1'b0, 16'h0000, 2};
    vecs[4]  = '{1'b0, 1'b1, 16'h000D, 16'h7777, 1'b0, 16'h0000, 2};
    vecs[5]  = '{1'b0, 1'b1, 16'h0005, 16'h5555, 1'b0, 16'h0000, 2};
    vecs[6]  = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h1234, 2};
    vecs[7]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hA5A5, 2};
    vecs[8]  = '{1'b1, 1'b0, 16'h0005, 16'h0000, 1'b1, 16'h5555, 2};
    vecs[9]  = '{1'b0, 1'b1, 16'h0010, 16'h0F0F, 1'b0, 16'h0000, 2};
    vecs[10] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'h0F0F, 2};
    vecs[11] = '{1'b0, 1'b1, 16'h0020, 16'h1111, 1'b0, 16'h0000, 2};
    vecs[12] = '{1'b1, 1'b1, 16'h0020, 16'h2222, 1'b1, 16'h1111, 2};
    vecs[13] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 16'h1111, 2};
    vecs[14] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'h0F0F, 2};
    // readback after the first acquisition reaches DONE
    vecs[15] = '{1'b1, 1'b0, 16'h0005, 16'h0000, 1'b1, 16'h0006, 2};
    vecs[16] = '{1'b1, 1'b0, 16'h0006, 16'h0000, 1'b1, 16'h0007, 2};
    vecs[17] = '{1'b1, 1'b0, 16'h0009, 16'h0000, 1'b1, 16'h000A, 2};
    vecs[18] = '{1'b1, 1'b0, 16'h000C, 16'h0000, 1'b1, 16'h000D, 2};
    vecs[19] = '{1'b1, 1'b0, 16'h000D, 16'h0000, 1'b1, 16'h7777, 2};
    vecs[20] = '{1'b1, 1'b0, 16'h0002, 16'h0000, 1'b1, 16'h0003, 2};

    Rst = 1'b1; vp_addr = '0; vp_wdata = '0; vp_rd = 1'b0; vp_wr = 1'b0;
    sample = '0; sv = 1'b0; arm = 1'b0; trig = 1'b0; post_trig = '0;
    s_vp_addr = '0; s_vp_wdata = '0; s_vp_rd = 1'b0; s_vp_wr = 1'b0; s_post_trig = 4'd4;
    tick(); tick();
    Rst = 1'b0;

    check("reset state", state, 0);
    check("reset wr_ptr", wr_ptr, 0);
    check("reset trig_addr", trig_addr, 0);
    check("reset rddata", vp_rdata, 0);
    check("reset rddone", vp_rddone, 0);
    check("reset wrdone", vp_wrdone, 0);

    for (int i = 0; i <= 13; i++) run_vec($sformatf("idle[%0d]", i), vecs[i]);
    check("idle state", state, 0);

    // second strobe while the first is pending is dropped
    vp_txn(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0, 1'b1, lat, grd, rdt, nd);
    check("ignored strobe latency", lat, 2);
    check("ignored strobe kind", grd, 1);
    check("ignored strobe rdata", rdt, 16'h0F0F);
    check("ignored strobe done count", nd, 1);
    run_vec("idle[14]", vecs[14]);

    // acquisition: post count 4, trigger on the 10th sample
    post_trig = 16'd4; arm = 1'b1; tick(); arm = 1'b0;
    check("arm state", state, 1);
    check("arm wr_ptr", wr_ptr, 0);
    for (int k = 1; k <= 6; k++) put_sample(16'(k), 1'b0);
    check("armed wr_ptr", wr_ptr, 6);

    vp_txn(1'b0, 1'b1, 16'h0005, 16'hDEAD, 1'b0, 16'h0, 1'b0, lat, grd, rdt, nd);
    check("armed write latency", lat, 2);
    check("armed write kind", grd, 0);
    check("armed write done count", nd, 1);

    vp_txn(1'b1, 1'b0, 16'h0002, 16'h0000, 1'b1, 16'h0007, 1'b0, lat, grd, rdt, nd);
    check("collide read latency", lat, 3);
    check("collide read kind", grd, 1);
    check("collide read rdata", rdt, 16'h0003);
    check("collide read done count", nd, 1);
    check("collide wr_ptr", wr_ptr, 7);

    put_sample(16'h0008, 1'b0);
    put_sample(16'h0009, 1'b0);
    check("pre-trig state", state, 1);
    put_sample(16'h000A, 1'b1);
    check("trig state", state, 2);
    check("trig addr", trig_addr, 9);
    put_sample(16'h000B, 1'b0);
    put_sample(16'h000C, 1'b0);
    check("post state", state, 2);
    check("post wr_ptr", wr_ptr, 12);
    put_sample(16'h000D, 1'b0);
    check("done state", state, 3);
    check("done wr_ptr", wr_ptr, 13);
    put_sample(16'h000E, 1'b0);
    check("done holds wr_ptr", wr_ptr, 13);
    trig = 1'b1; tick(); trig = 1'b0;
    check("trig in done state", state, 3);
    check("trig in done addr", trig_addr, 9);

    for (int i = 15; i <= 20; i++) run_vec($sformatf("done[%0d]", i), vecs[i]);

    // post count 0 acts as 1; trigger without a sample takes the next one
    post_trig = 16'd0; arm = 1'b1; tick(); arm = 1'b0;
    check("rearm state", state, 1);
    check("rearm wr_ptr", wr_ptr, 0);
    put_sample(16'h0021, 1'b0);
    trig = 1'b1; tick(); trig = 1'b0;
    check("late trig state", state, 2);
    check("late trig addr unchanged", trig_addr, 9);
    put_sample(16'h0022, 1'b0);
    check("late trig done", state, 3);
    check("late trig addr", trig_addr, 1);
    check("late trig wr_ptr", wr_ptr, 2);
    v = '{1'b1, 1'b0, 16'h0001, 16'h0000, 1'b1, 16'h0022, 2};
    run_vec("late trig sample", v);

    // arm while armed restarts
    post_trig = 16'd5; arm = 1'b1; tick(); arm = 1'b0;
    put_sample(16'h0031, 1'b0);
    put_sample(16'h0032, 1'b0);
    check("restart pre wr_ptr", wr_ptr, 2);
    arm = 1'b1; tick(); arm = 1'b0;
    check("restart state", state, 1);
    check("restart wr_ptr", wr_ptr, 0);

    // wrap on the 4-bit instance, 20 pre-trigger samples
    post_trig = 16'd4; arm = 1'b1; tick(); arm = 1'b0;
    for (int k = 1; k <= 15; k++) put_sample(16'(k), 1'b0);
    check("small pre-wrap ptr", s_wr_ptr, 15);
`ifdef ACQ_VP_RAM_WRAP_FLAG_EN
    check("small pre-wrap flag", s_wrapped, 0);
`endif
    put_sample(16'd16, 1'b0);
    check("small wrap ptr", s_wr_ptr, 0);
    for (int k = 17; k <= 20; k++) put_sample(16'(k), 1'b0);
    check("small wrapped ptr", s_wr_ptr, 4);
    check("small wrapped state", s_state, 1);
    check("main no wrap ptr", wr_ptr, 20);
`ifdef ACQ_VP_RAM_WRAP_FLAG_EN
    check("small wrapped flag", s_wrapped, 1);
    check("main wrapped flag", wrapped, 0);
`endif
    arm = 1'b1; tick(); arm = 1'b0;
    check("small rearm ptr", s_wr_ptr, 0);
`ifdef ACQ_VP_RAM_WRAP_FLAG_EN
    check("small rearm flag", s_wrapped, 0);
`endif

    // reset in POST with a read pending
    put_sample(16'h0055, 1'b1);
    check("pre-reset state", state, 2);
    vp_rd = 1'b1; vp_addr = 16'h0010;
    tick();
    vp_rd = 1'b0; Rst = 1'b1;
    tick();
    Rst = 1'b0;
    check("post-reset state", state, 0);
    check("post-reset wr_ptr", wr_ptr, 0);
    check("post-reset trig_addr", trig_addr, 0);
    check("post-reset rddone", vp_rddone, 0);
    check("post-reset wrdone", vp_wrdone, 0);
    check("post-reset rddata", vp_rdata, 0);
    check("post-reset small state", s_state, 0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (vp_rddone || vp_wrdone) cnt++;
    end
    check("dropped request no done", cnt, 0);
    v = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'h0011, 2};
    run_vec("after reset read", v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
